// File: rtl/gb_serial_port_pkg.sv
// -----------------------------------------------------------------------------
// gb_serial_port_pkg
//
// Shared definitions for the Game Boy link-cable serial port:
//   - I/O addresses of the SB (shift data) and SC (control) registers
//   - serial FSM state encoding (2 bits)
//   - interrupt-flag bit the interrupt controller ORs oInterrupt into
//   - bit count of one transfer and the SC read-back formatter
// -----------------------------------------------------------------------------
package gb_serial_port_pkg;

   // MMU I/O addresses
   localparam logic [15:0] SERIAL_SB = 16'hFF01;
   localparam logic [15:0] SERIAL_SC = 16'hFF02;

   // IF register bit owned by the serial port
   localparam int unsigned INT_SERIAL_BIT = 3;

   // Bits shifted per transfer; the bit counter runs 0..XFER_BITS
   localparam logic [3:0] XFER_BITS = 4'd8;

   // Serial FSM states
   typedef enum logic [1:0] {
      SER_IDLE = 2'd0,
      SER_LOW  = 2'd1,
      SER_HIGH = 2'd2
   } ser_state_e;

   // SC reads back with the unimplemented bits 6..1 set
   function automatic logic [7:0] sc_read(input logic start, input logic clksel);
      return {start, 6'b111111, clksel};
   endfunction

endpackage

// File: rtl/gb_serial_port_sync2.sv
// -----------------------------------------------------------------------------
// gb_serial_port_sync2
//
// Two-flop synchronizer (1 bit, reset value 1) for the asynchronous link-cable
// pins. Both link pins idle high, so resetting to 1 keeps a reset from looking
// like a falling edge on the external clock.
//
// Ports:
//   iClock  - system clock
//   iReset  - synchronous active-high reset, forces both flops to 1
//   iAsync  - asynchronous input pin
//   oSync   - synchronized output, two cycles behind iAsync
// -----------------------------------------------------------------------------
module gb_serial_port_sync2 (
   input  logic iClock,
   input  logic iReset,
   input  logic iAsync,
   output logic oSync
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge iClock) begin
      if (iReset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= iAsync;
         sync_q <= meta_q;
      end
   end

   assign oSync = sync_q;

endmodule

// File: rtl/gb_serial_port.sv
// -----------------------------------------------------------------------------
// gb_serial_port
//
// Game Boy link-cable serial port. Responds on the MMU I/O bus at SB (0xFF01)
// and SC (0xFF02). A transfer shifts SB out MSB-first on oSerialOut while the
// bits arriving on iSerialIn are shifted in at the LSB. The serial clock is
// either generated internally (CLOCK_DIV system cycles per half period) or
// taken from the link partner on iSerialClockExt. Completion raises a
// one-cycle oInterrupt pulse.
//
// Parameters:
//   CLOCK_DIV        - system cycles per serial-clock half period (1..65535)
//
// Ports:
//   iClock           - system clock, rising edge
//   iReset           - synchronous active-high reset
//   iAddr            - MMU address bus
//   iData            - MMU write data
//   iWe              - write strobe
//   oData            - combinational read data (0x00 when not selected)
//   oHit             - combinational, 1 when iAddr selects SB or SC
//   oSerialClock     - serial clock out, idles high, driven only internally
//   oSerialOut       - serial data out (always SB[7])
//   iSerialIn        - serial data in, asynchronous
//   iSerialClockExt  - external serial clock, asynchronous
//   oInterrupt       - one-cycle pulse at transfer completion
// -----------------------------------------------------------------------------
module gb_serial_port
   import gb_serial_port_pkg::*;
#(
   parameter int unsigned CLOCK_DIV = 256
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic [15:0] iAddr,
   input  logic [7:0]  iData,
   input  logic        iWe,
   output logic [7:0]  oData,
   output logic        oHit,
   output logic        oSerialClock,
   output logic        oSerialOut,
   input  logic        iSerialIn,
   input  logic        iSerialClockExt,
   output logic        oInterrupt
);

   localparam logic [15:0] DIV_LAST = 16'(CLOCK_DIV - 1);

   // Architectural registers
   logic [7:0]  sb_q;
   logic        start_q;
   logic        clksel_q;

   // Transfer machinery
   ser_state_e  state_q;
   logic        xfer_int_q;    // clock source latched at start of transfer
   logic [3:0]  cnt_q;
   logic [15:0] div_q;
   logic [15:0] div_d;
   logic        sclk_q;
   logic        irq_q;
   logic        ext_prev_q;

   // Synchronized pins and decoded events
   logic        sin_sync;
   logic        sclk_ext_sync;
   logic        ext_rise;
   logic        ext_fall;
   logic        div_last;
   logic        low_done;
   logic        high_done;

   // Bus decode
   logic        sel_sb;
   logic        sel_sc;
   logic        sb_wr;
   logic        sc_wr;
   logic        abort;

   gb_serial_port_sync2 u_sync_sin (
      .iClock (iClock),
      .iReset (iReset),
      .iAsync (iSerialIn),
      .oSync  (sin_sync)
   );

   gb_serial_port_sync2 u_sync_sclk (
      .iClock (iClock),
      .iReset (iReset),
      .iAsync (iSerialClockExt),
      .oSync  (sclk_ext_sync)
   );

   assign sel_sb = (iAddr == SERIAL_SB);
   assign sel_sc = (iAddr == SERIAL_SC);
   assign sb_wr  = iWe & sel_sb;
   assign sc_wr  = iWe & sel_sc;

   // A stop write during a transfer wins over any phase completion in the
   // same cycle, including the final one, so no interrupt can slip out.
   assign abort  = sc_wr & ~iData[7] & (state_q != SER_IDLE);

   // Edge detection on the synchronized external clock
   assign ext_rise = sclk_ext_sync & ~ext_prev_q;
   assign ext_fall = ~sclk_ext_sync & ext_prev_q;

   // Divider restarts from 0 on every state change, so a half period ends
   // when it has counted CLOCK_DIV cycles in the current state.
   assign div_d     = div_q + 16'd1;
   assign div_last  = (div_q == DIV_LAST);
   assign low_done  = xfer_int_q ? div_last : ext_rise;
   assign high_done = xfer_int_q ? div_last : ext_fall;

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_q    <= SER_IDLE;
         sb_q       <= 8'h00;
         start_q    <= 1'b0;
         clksel_q   <= 1'b0;
         xfer_int_q <= 1'b0;
         cnt_q      <= 4'd0;
         div_q      <= 16'd0;
         sclk_q     <= 1'b1;
         irq_q      <= 1'b0;
         ext_prev_q <= 1'b1;
      end else begin
         ext_prev_q <= sclk_ext_sync;
         irq_q      <= 1'b0;

         // clksel always follows SC writes; an active transfer keeps using
         // its latched copy in xfer_int_q.
         if (sc_wr) begin
            clksel_q <= iData[0];
         end

         if (abort) begin
            state_q <= SER_IDLE;
            start_q <= 1'b0;
            div_q   <= 16'd0;
            sclk_q  <= 1'b1;
         end else begin
            unique case (state_q)
               SER_IDLE: begin
                  sclk_q <= 1'b1;
                  if (sb_wr) begin
                     sb_q <= iData;
                  end
                  if (sc_wr && iData[7]) begin
                     state_q    <= SER_LOW;
                     start_q    <= 1'b1;
                     xfer_int_q <= iData[0];
                     cnt_q      <= 4'd0;
                     div_q      <= 16'd0;
                     // Pin only drops when we own the clock
                     sclk_q     <= ~iData[0];
                  end
               end

               SER_LOW: begin
                  if (low_done) begin
                     state_q <= SER_HIGH;
                     sb_q    <= {sb_q[6:0], sin_sync};
                     cnt_q   <= cnt_q + 4'd1;
                     div_q   <= 16'd0;
                     sclk_q  <= 1'b1;
                  end else begin
                     div_q <= div_d;
                  end
               end

               SER_HIGH: begin
                  if (high_done) begin
                     div_q <= 16'd0;
                     if (cnt_q == XFER_BITS) begin
                        state_q <= SER_IDLE;
                        start_q <= 1'b0;
                        irq_q   <= 1'b1;
                        sclk_q  <= 1'b1;
                     end else begin
                        state_q <= SER_LOW;
                        sclk_q  <= ~xfer_int_q;
                     end
                  end else begin
                     div_q <= div_d;
                  end
               end

               default: begin
                  state_q <= SER_IDLE;
                  sclk_q  <= 1'b1;
               end
            endcase
         end
      end
   end

   // Combinational read port
   always_comb begin
      oData = 8'h00;
      if (sel_sb) begin
         oData = sb_q;
      end else if (sel_sc) begin
         oData = sc_read(start_q, clksel_q);
      end
   end

   assign oHit         = sel_sb | sel_sc;
   assign oSerialClock = sclk_q;
   assign oSerialOut   = sb_q[7];
   assign oInterrupt   = irq_q;

endmodule

// File: tb/tb_gb_serial_port.sv
module tb_gb_serial_port;

   localparam int DIV  = 4;
   localparam int XFER = 16 * DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic        sin = 1'b1;
   logic        sext = 1'b1;
   logic [15:0] addr = 16'h0000;
   logic [7:0]  wdata = 8'h00;
   logic [7:0]  rdata;
   logic        hit, sclk, sout, irq;

   int errors = 0;
   int checks = 0;
   int irq_cnt = 0;
   int sclk_low_cnt = 0;

   always #5 clk = ~clk;

   gb_serial_port #(.CLOCK_DIV(DIV)) dut (
      .iClock          (clk),
      .iReset          (rst),
      .iAddr           (addr),
      .iData           (wdata),
      .iWe             (we),
      .oData           (rdata),
      .oHit            (hit),
      .oSerialClock    (sclk),
      .oSerialOut      (sout),
      .iSerialIn       (sin),
      .iSerialClockExt (sext),
      .oInterrupt      (irq)
   );

   typedef struct {
      logic [15:0] waddr;
      logic        we;
      logic [7:0]  wdata;
      logic [15:0] raddr;
      logic [7:0]  exp_d;
      logic        exp_hit;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (irq === 1'b1) irq_cnt++;
      if (sclk !== 1'b1) sclk_low_cnt++;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      addr = a; wdata = d; we = 1'b1;
      @(negedge clk);
      we = 1'b0; addr = 16'h0000; wdata = 8'h00;
   endtask

   task automatic chk_rd(input string name, input logic [15:0] a, input logic [7:0] exp);
      logic [7:0] d;
      addr = a;
      #1;
      d = rdata;
      addr = 16'h0000;
      chk(name, {24'h0, d}, {24'h0, exp});
   endtask

   task automatic do_reset();
      rst = 1'b1; we = 1'b0; addr = 16'h0000; wdata = 8'h00;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Internal-clock transfer against a bit-level model: the expected serial
   // clock is low in even half periods, oSerialOut presents tx MSB-first in
   // each low half, and the received byte is assembled MSB-first from rx.
   task automatic run_int(input logic [7:0] tx, input logic [7:0] rx,
                          input bit loopback, input string tag);
      int sclk_bad, sout_bad, nint, int_c, ph;
      logic exp_sclk;
      logic [7:0] exp_sb;
      sclk_bad = 0; sout_bad = 0; nint = 0; int_c = -1;
      exp_sb = loopback ? tx : rx;
      wr(16'hFF01, tx);
      wr(16'hFF02, 8'h81);
      for (int c = 1; c <= XFER + 4; c++) begin
         ph = (c - 1) / DIV;
         exp_sclk = (c <= XFER) ? ph[0] : 1'b1;
         if (sclk !== exp_sclk) sclk_bad++;
         if (c <= XFER && ph[0] == 1'b0 && sout !== tx[7 - ph / 2]) sout_bad++;
         if (irq === 1'b1) begin nint++; int_c = c; end
         if (loopback) sin = sout;
         else if (c <= XFER && ph[0] == 1'b0 && (c - 1) % DIV == 0) sin = rx[7 - ph / 2];
         @(negedge clk);
      end
      chk({tag, "_sclk_wave"}, sclk_bad, 0);
      chk({tag, "_sout_bits"}, sout_bad, 0);
      chk({tag, "_irq_count"}, nint, 1);
      chk({tag, "_irq_cycle"}, int_c, XFER + 1);
      chk_rd({tag, "_sb"}, 16'hFF01, exp_sb);
      chk_rd({tag, "_sc"}, 16'hFF02, 8'h7F);
   endtask

   initial begin
      logic [7:0] tx, rx;
      logic [7:0] d;
      int int_k, irq_c;

      // Reset state
      do_reset();
      chk("rst_sclk", {31'h0, sclk}, 1);
      chk("rst_sout", {31'h0, sout}, 0);
      chk("rst_irq", {31'h0, irq}, 0);

      // Register access table: one cycle with the write strobe, then a read
      vecs[0]  = '{16'hFF00, 1'b0, 8'h00, 16'hFF01, 8'h00, 1'b1};
      vecs[1]  = '{16'hFF00, 1'b0, 8'h00, 16'hFF02, 8'h7E, 1'b1};
      vecs[2]  = '{16'hFF01, 1'b1, 8'h5A, 16'hFF01, 8'h5A, 1'b1};
      vecs[3]  = '{16'hFF02, 1'b1, 8'h01, 16'hFF02, 8'h7F, 1'b1};
      vecs[4]  = '{16'hFF00, 1'b0, 8'h00, 16'hFF03, 8'h00, 1'b0};
      vecs[5]  = '{16'hFF00, 1'b0, 8'h00, 16'hFF00, 8'h00, 1'b0};
      vecs[6]  = '{16'hFF02, 1'b1, 8'h00, 16'hFF02, 8'h7E, 1'b1};
      vecs[7]  = '{16'hFF03, 1'b1, 8'hFF, 16'hFF01, 8'h5A, 1'b1};
      vecs[8]  = '{16'hFF01, 1'b0, 8'h11, 16'hFF01, 8'h5A, 1'b1};
      vecs[9]  = '{16'hFF01, 1'b1, 8'hC3, 16'hFF01, 8'hC3, 1'b1};
      vecs[10] = '{16'hFF02, 1'b1, 8'h7F, 16'hFF02, 8'h7F, 1'b1};
      vecs[11] = '{16'hFF02, 1'b1, 8'h00, 16'hFF02, 8'h7E, 1'b1};
      for (int i = 0; i < 12; i++) begin
         addr = vecs[i].waddr; wdata = vecs[i].wdata; we = vecs[i].we;
         @(negedge clk);
         we = 1'b0;
         addr = vecs[i].raddr;
         #1;
         chk($sformatf("vec%0d_data", i), {24'h0, rdata}, {24'h0, vecs[i].exp_d});
         chk($sformatf("vec%0d_hit", i), {31'h0, hit}, {31'h0, vecs[i].exp_hit});
         addr = 16'h0000;
      end
      chk("idle_sout_msb", {31'h0, sout}, 1);
      chk("idle_sclk", {31'h0, sclk}, 1);

      // Directed transfers
      run_int(8'hA5, 8'hA5, 1'b1, "loopA5");
      sin = 1'b1;
      run_int(8'hA5, 8'hFF, 1'b0, "sin1A5");

      // Randomized transfers
      for (int i = 0; i < 6; i++) begin
         tx = 8'($urandom_range(255));
         rx = 8'($urandom_range(255));
         run_int(tx, rx, 1'b0, $sformatf("rnd%0d", i));
      end
      tx = 8'($urandom_range(255));
      run_int(tx, tx, 1'b1, "rndloop");

      // Abort after the 3rd rising edge
      do_reset();
      sin = 1'b1;
      wr(16'hFF01, 8'h0F);
      wr(16'hFF02, 8'h81);
      repeat (20) step();
      wr(16'hFF02, 8'h01);
      chk_rd("abort_sb", 16'hFF01, 8'((8'h0F << 3) | 8'h07));
      chk_rd("abort_sc", 16'hFF02, 8'h7F);
      chk("abort_sclk", {31'h0, sclk}, 1);
      irq_cnt = 0; sclk_low_cnt = 0;
      repeat (80) step();
      chk("abort_no_irq", irq_cnt, 0);
      chk("abort_sclk_idle", sclk_low_cnt, 0);
      chk_rd("abort_sb_hold", 16'hFF01, 8'h7F);

      // Stop write on the same edge as the final serial edge
      do_reset();
      sin = 1'b0;
      wr(16'hFF01, 8'h81);
      wr(16'hFF02, 8'h81);
      repeat (XFER - 1) step();
      wr(16'hFF02, 8'h01);
      chk("collide_irq", {31'h0, irq}, 0);
      chk_rd("collide_sc", 16'hFF02, 8'h7F);
      irq_cnt = 0;
      repeat (10) step();
      chk("collide_no_irq", irq_cnt, 0);

      // Start write in the cycle oInterrupt is high
      do_reset();
      sin = 1'b1;
      wr(16'hFF01, 8'h00);
      wr(16'hFF02, 8'h81);
      repeat (XFER) step();
      chk("restart_irq", {31'h0, irq}, 1);
      wr(16'hFF02, 8'h81);
      chk("restart_sclk", {31'h0, sclk}, 0);
      chk_rd("restart_sc", 16'hFF02, 8'hFF);
      chk_rd("restart_sb", 16'hFF01, 8'hFF);

      // SC write with start=1 mid-transfer only touches clksel
      do_reset();
      sin = 1'b0;
      wr(16'hFF01, 8'hF0);
      wr(16'hFF02, 8'h81);
      repeat (9) step();
      wr(16'hFF02, 8'h80);
      chk_rd("clksel_upd_sc", 16'hFF02, 8'hFE);
      irq_c = -1;
      for (int c = 11; c <= XFER + 6; c++) begin
         if (irq === 1'b1) irq_c = c;
         @(negedge clk);
      end
      chk("clksel_upd_irq_cycle", irq_c, XFER + 1);
      chk_rd("clksel_upd_sc_end", 16'hFF02, 8'h7E);
      chk_rd("clksel_upd_sb_end", 16'hFF01, 8'h00);

      // External clock: 8 pulses of 6 high / 6 low
      do_reset();
      sext = 1'b0; sin = 1'b0;
      repeat (4) step();
      wr(16'hFF01, 8'h3C);
      wr(16'hFF02, 8'h80);
      irq_cnt = 0; sclk_low_cnt = 0; int_k = -1;
      for (int p = 0; p < 8; p++) begin
         sext = 1'b1;
         repeat (6) step();
         sext = 1'b0;
         for (int k = 1; k <= 6; k++) begin
            step();
            if (p == 7 && irq === 1'b1) int_k = k;
         end
      end
      chk("ext_irq_count", irq_cnt, 1);
      chk("ext_irq_delay", int_k, 3);
      chk("ext_sclk_high", sclk_low_cnt, 0);
      chk_rd("ext_sb", 16'hFF01, 8'h00);
      chk_rd("ext_sc", 16'hFF02, 8'h7E);
      sext = 1'b1;
      repeat (4) step();

      // SB write ignored mid-transfer, then reset mid-transfer
      do_reset();
      sin = 1'b1;
      wr(16'hFF01, 8'hA5);
      wr(16'hFF02, 8'h81);
      repeat (5) step();
      wr(16'hFF01, 8'h33);
      chk_rd("busy_sb_write", 16'hFF01, 8'(((8'hA5) << 1) | 8'h01));
      repeat (13) step();
      rst = 1'b1;
      step();
      chk_rd("midrst_sb", 16'hFF01, 8'h00);
      chk_rd("midrst_sc", 16'hFF02, 8'h7E);
      chk("midrst_sclk", {31'h0, sclk}, 1);
      chk("midrst_sout", {31'h0, sout}, 0);
      chk("midrst_irq", {31'h0, irq}, 0);
      rst = 1'b0;
      irq_cnt = 0; sclk_low_cnt = 0;
      repeat (70) step();
      chk("midrst_no_irq", irq_cnt, 0);
      chk("midrst_sclk_idle", sclk_low_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gb_serial_port.md
# gb_serial_port

Game Boy link-cable serial port (SB at 0xFF01, SC at 0xFF02), a responder on the MMU I/O bus that the DZCPU drives with its `iAddr`, `iData`, `iWe` writes and reads. It shifts 8 bits out MSB-first while shifting 8 bits in, using either an internally generated serial clock or an external one. On completion it raises a one-cycle serial interrupt request to the interrupt controller. It sits beside the LCD and sound blocks in the MMU I/O decode region (0xFF00–0xFF7F).

## Interface
- `CLOCK_DIV`, default 256: system cycles per serial-clock half period. 256 gives 8192 Hz at 4.194304 MHz. Legal range is 1..65535.
- `iClock` in 1: system clock; everything is clocked on its rising edge.
- `iReset` in 1: synchronous, active-high reset.
- `iAddr` in 16: MMU address bus.
- `iData` in 8: MMU write data.
- `iWe` in 1: write strobe, sampled at the clock edge when `iAddr` is 0xFF01 or 0xFF02.
- `oData` out 8: read data, combinational from `iAddr`; 0x00 when neither address is selected.
- `oHit` out 1: combinational; 1 when `iAddr` is 0xFF01 or 0xFF02.
- `oSerialClock` out 1: serial clock output; idles high and is driven only in internal-clock mode.
- `oSerialOut` out 1: serial data out.
- `iSerialIn` in 1: serial data in, asynchronous.
- `iSerialClockExt` in 1: external serial clock, asynchronous.
- `oInterrupt` out 1: one-cycle pulse when a transfer completes.

## Operation
**Registers**
- SB[7:0] is the shift register. Writes to SB are ignored while a transfer is active.
- SC holds `start` (bit 7) and `clksel` (bit 0); 1 selects the internal clock. SC reads return {start, 6'b111111, clksel}.
- Writing SC with bit 7 = 1 while idle starts a transfer.
- Writing SC with bit 7 = 0 while active aborts: the FSM returns to IDLE, SB keeps its partially shifted value, and no interrupt fires.
- Writing SC with bit 7 = 1 while already active only updates `clksel`, and that update takes effect on the next transfer.

**State machine: IDLE → SHIFT_LOW → SHIFT_HIGH → (SHIFT_LOW or IDLE)**
- IDLE: `oSerialClock` = 1, `oSerialOut` = SB[7]. A start write goes to SHIFT_LOW, clears the bit counter and the divider, and latches `clksel`.
- SHIFT_LOW: `oSerialClock` = 0 and `oSerialOut` = SB[7]. The state ends after `CLOCK_DIV` cycles in internal mode, or on a synchronized rising edge of the external clock in external mode. Then go to SHIFT_HIGH and sample: SB <= {SB[6:0], iSerialIn_sync}, bit counter +1.
- SHIFT_HIGH: `oSerialClock` = 1. The state ends after `CLOCK_DIV` cycles in internal mode, or on a synchronized falling edge in external mode.
  - If the counter is below 8, go back to SHIFT_LOW.
  - If the counter is 8, go to IDLE, clear SC[7] and pulse `oInterrupt`.
- The bit counter is 4 bits wide and counts 0..8. The divider is 16 bits and resets to 0 on every state change.

**Synchronization**
- `iSerialIn` and `iSerialClockExt` each pass through a 2-flop synchronizer.
- External edges are detected by comparing the current and previous synchronized values.
- In external mode `oSerialClock` is held at 1.

**Boundary conditions**
- If a SC write with start = 0 lands in the same cycle as the final edge, the abort wins: no interrupt, SC[7] = 0.
- A start write in the same cycle as `oInterrupt` starts a new transfer.
- `iReset` mid-transfer returns everything to its reset values immediately.

## Timing
- Reset values:
  - SB = 0x00, SC.start = 0, SC.clksel = 0, state = IDLE.
  - `oSerialClock` = 1, `oSerialOut` = 0, `oInterrupt` = 0, synchronizer flops = 1.
- Start latency: `oSerialClock` falls on the first cycle after the start-write edge.
- Internal-mode transfer: 16×`CLOCK_DIV` cycles from the start-write edge to SC[7] = 0. `oInterrupt` is high during cycle 16×`CLOCK_DIV` + 1. With `CLOCK_DIV` = 4 that is 64 cycles.
- `iSerialIn` is captured from its value 2–3 cycles before each internal rising edge, due to the synchronizer.
- External mode: each edge is acted on 3 cycles after the pin transition. The external clock needs a high time and a low time of at least 3 cycles each.
- `oData` and `oHit` have zero-cycle combinational read latency; register updates are visible on the cycle after the write edge.

## Structure
- Add to `aDefinitions.v`:
  - `` `SERIAL_SB `` = 16'hFF01 and `` `SERIAL_SC `` = 16'hFF02.
  - State encodings `` `SER_IDLE ``, `` `SER_LOW ``, `` `SER_HIGH `` (2 bits).
  - `` `INT_SERIAL_BIT `` = 3, the IF bit the interrupt controller ORs `oInterrupt` into.
- One sub-module, `sync2`: a 2-flop synchronizer with 1-bit width and reset value 1, instantiated twice.
- The FSM, divider and registers live in `gb_serial_port`. The MMU instantiates it and muxes `oData` when `oHit` = 1.

## Test plan
- Loopback, `CLOCK_DIV` = 4, `iSerialIn` tied to `oSerialOut`: write SB = 0xA5, SC = 0x81 → after 64 cycles SB = 0xA5, SC reads 0x7F, one `oInterrupt` pulse.
- `iSerialIn` = 1, SB = 0xA5, SC = 0x81 → `oSerialOut` during the eight low phases is 1,0,1,0,0,1,0,1, final SB = 0xFF, and each `oSerialClock` low/high phase lasts exactly 4 cycles.
- Abort: start SB = 0x0F, then write SC = 0x01 after the 3rd rising edge → state IDLE, SB = 0x7F with `iSerialIn` = 1, no interrupt, `oSerialClock` = 1.
- External mode: SC = 0x80 with SB = 0x3C and 8 external pulses of 6 cycles high / 6 cycles low, `iSerialIn` = 0 → SB = 0x00, interrupt 3 cycles after the 8th falling edge, `oSerialClock` stays 1.
- Reset mid-transfer after 20 cycles → SB = 0x00, SC reads 0x7E, `oSerialClock` = 1, no interrupt. A write to SB during a transfer leaves SB unchanged.
- Reads: `iAddr` = 0xFF02 while idle with `clksel` = 1 → `oData` = 0x7F and `oHit` = 1. `iAddr` = 0xFF03 → `oHit` = 0 and `oData` = 0x00.
